// File: rtl/interlaken_metaframe_ctrl.sv
// Interlaken per-lane metaframe sequencer.
// Carves the lane word stream into fixed-length metaframes in the order
// sync, scrambler-state, skip, payload..., diagnostic. It drives the
// scrambler strobes and data word one cycle after the slot is decoded.
module interlaken_metaframe_ctrl #(
    parameter int unsigned METAFRAME_LEN = 2048,
    parameter logic [63:0] SKIP_WORD     = 64'h1E1E_1E1E_1E1E_1E1E,
    parameter logic [63:0] IDLE_WORD     = 64'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [63:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  lane_status,
    output logic [63:0] data_out,
    output logic        word_is_synchronization,
    output logic        word_is_scrambler_state,
    output logic        word_is_to_be_scrambled,
    output logic        metaframe_start,
    output logic        idle_inserted
);

    localparam int unsigned       SLOT_W    = $clog2(METAFRAME_LEN);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(METAFRAME_LEN - 1);
    localparam logic [5:0]        DIAG_HDR  = 6'b011001;

    typedef enum logic [2:0] {
        K_SYNC,
        K_SCRAM_STATE,
        K_SKIP,
        K_PAYLOAD,
        K_DIAG
    } slot_kind_e;

    logic [SLOT_W-1:0] slot;
    slot_kind_e        kind_c;
    logic [63:0]       diag_word_c;

    // Classify the current slot position within the metaframe.
    always_comb begin
        kind_c = K_PAYLOAD;
        if (slot == '0) begin
            kind_c = K_SYNC;
        end else if (slot == SLOT_W'(1)) begin
            kind_c = K_SCRAM_STATE;
        end else if (slot == SLOT_W'(2)) begin
            kind_c = K_SKIP;
        end else if (slot == SLOT_LAST) begin
            kind_c = K_DIAG;
        end
    end

    // Diagnostic word; CRC32 field in bits 31:0 is filled downstream.
    always_comb begin
        diag_word_c = {DIAG_HDR, 24'h0, lane_status, 32'h0};
    end

    // Payload is only accepted in payload slots of an advancing, non-reset cycle.
    assign in_ready = enable & ~reset & (kind_c == K_PAYLOAD);

    // Slot counter: advances on enable, wraps after the diagnostic word.
    always_ff @(posedge clk) begin
        if (reset) begin
            slot <= '0;
        end else if (enable) begin
            if (slot == SLOT_LAST) begin
                slot <= '0;
            end else begin
                slot <= slot + SLOT_W'(1);
            end
        end
    end

    // Registered word and strobes for the slot issued this cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_out                <= '0;
            word_is_synchronization <= 1'b0;
            word_is_scrambler_state <= 1'b0;
            word_is_to_be_scrambled <= 1'b0;
            metaframe_start         <= 1'b0;
            idle_inserted           <= 1'b0;
        end else begin
            word_is_synchronization <= 1'b0;
            word_is_scrambler_state <= 1'b0;
            word_is_to_be_scrambled <= 1'b0;
            metaframe_start         <= 1'b0;
            idle_inserted           <= 1'b0;
            if (enable) begin
                unique case (kind_c)
                    K_SYNC: begin
                        word_is_synchronization <= 1'b1;
                        metaframe_start         <= 1'b1;
                        data_out                <= '0;
                    end
                    K_SCRAM_STATE: begin
                        word_is_scrambler_state <= 1'b1;
                        data_out                <= '0;
                    end
                    K_SKIP: begin
                        word_is_to_be_scrambled <= 1'b1;
                        data_out                <= SKIP_WORD;
                    end
                    K_PAYLOAD: begin
                        word_is_to_be_scrambled <= 1'b1;
                        if (in_valid) begin
                            data_out <= in_data;
                        end else begin
                            data_out      <= IDLE_WORD;
                            idle_inserted <= 1'b1;
                        end
                    end
                    K_DIAG: begin
                        word_is_to_be_scrambled <= 1'b1;
                        data_out                <= diag_word_c;
                    end
                    default: begin
                        data_out <= data_out;
                    end
                endcase
            end
        end
    end

endmodule
